// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache. Misses refill a whole line over a word-wide,
// in-order, pipelined memory port; flush_i invalidates every line for fence.i.
module icache_dm #(
    parameter int unsigned ADDRW      = 32,
    parameter int unsigned DATAW      = 32,
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [ADDRW-1:0] imem_addr_i,
    input  logic             imem_valid_i,
    output logic [DATAW-1:0] imem_rdata_o,
    output logic             imem_resp_o,
    input  logic             flush_i,
    output logic             mem_req_o,
    output logic [ADDRW-1:0] mem_addr_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [DATAW-1:0] mem_rdata_i
);
    localparam int unsigned WB = $clog2(LINE_WORDS);
    localparam int unsigned IB = $clog2(NUM_LINES);
    localparam int unsigned TB = ADDRW - IB - WB - 2;
    localparam logic [WB-1:0] LastWord = WB'(LINE_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StLookup, StRefill, StRespond} state_e;

    state_e               state_q;
    logic [ADDRW-1:0]     req_addr_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [WB-1:0]        req_cnt_q;
    logic [WB-1:0]        rsp_cnt_q;
    logic                 req_done_q;
    logic                 flush_pend_q;

    logic [TB-1:0]        tag_q  [NUM_LINES];
    logic [DATAW-1:0]     data_q [NUM_LINES][LINE_WORDS];

    logic [WB-1:0]        req_word;
    logic [IB-1:0]        req_index;
    logic [TB-1:0]        req_tag;
    logic                 hit;
    logic                 resp;
    logic                 refill_wr;
    logic                 refill_last;
    logic                 unused_offset;

    assign req_word      = req_addr_q[2 +: WB];
    assign req_index     = req_addr_q[2 + WB +: IB];
    assign req_tag       = req_addr_q[ADDRW-1 -: TB];
    assign unused_offset = ^req_addr_q[1:0];

    assign hit  = (state_q == StLookup) && valid_q[req_index] && (tag_q[req_index] == req_tag);
    // RESPOND is a forced hit so the fetched word is returned even if a flush kept it invalid
    assign resp = hit || (state_q == StRespond);

    assign imem_resp_o  = resp;
    assign imem_rdata_o = resp ? data_q[req_index][req_word] : '0;
    assign mem_req_o    = (state_q == StRefill) && !req_done_q;
    assign mem_addr_o   = mem_req_o ? {req_tag, req_index, req_cnt_q, 2'b00} : '0;

    assign refill_wr   = (state_q == StRefill) && mem_rvalid_i;
    assign refill_last = refill_wr && (rsp_cnt_q == LastWord);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            req_addr_q   <= '0;
            valid_q      <= '0;
            req_cnt_q    <= '0;
            rsp_cnt_q    <= '0;
            req_done_q   <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StRespond: begin
                    if (imem_valid_i) begin
                        req_addr_q <= imem_addr_i;
                        state_q    <= StLookup;
                    end else begin
                        state_q    <= StIdle;
                    end
                    if (flush_i) valid_q <= '0;
                end
                StLookup: begin
                    if (!hit) begin
                        state_q    <= StRefill;
                        req_cnt_q  <= '0;
                        rsp_cnt_q  <= '0;
                        req_done_q <= 1'b0;
                    end else if (imem_valid_i) begin
                        req_addr_q <= imem_addr_i;
                        state_q    <= StLookup;
                    end else begin
                        state_q    <= StIdle;
                    end
                    if (flush_i) valid_q <= '0;
                end
                StRefill: begin
                    if (mem_req_o && mem_gnt_i) begin
                        req_cnt_q <= req_cnt_q + WB'(1);
                        if (req_cnt_q == LastWord) req_done_q <= 1'b1;
                    end
                    if (flush_i) flush_pend_q <= 1'b1;
                    if (mem_rvalid_i) begin
                        rsp_cnt_q <= rsp_cnt_q + WB'(1);
                    end
                    if (refill_last) begin
                        state_q      <= StRespond;
                        flush_pend_q <= 1'b0;
                        // A flush seen at any point of the fill must not leave stale lines valid
                        if (flush_pend_q || flush_i) begin
                            valid_q <= '0;
                        end else begin
                            valid_q[req_index] <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk_i) begin
        if (refill_wr) begin
            data_q[req_index][rsp_cnt_q] <= mem_rdata_i;
        end
        if (refill_last) begin
            tag_q[req_index] <= req_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, hits, eviction, backpressure, flush and reset.
module tb_icache_dm;
    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        gnt_q;
    logic        stall;
    logic [31:0] acc_q[$];

    int n_checks;
    int n_fails;

    icache_dm dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .imem_addr_i  (imem_addr),
        .imem_valid_i (imem_valid),
        .imem_rdata_o (imem_rdata),
        .imem_resp_o  (imem_resp),
        .flush_i      (flush),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: grant one cycle after request, data one cycle after grant, word = addr ^ DEAD0000
    assign mem_gnt = gnt_q && !stall;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q      <= 1'b0;
            mem_rvalid <= 1'b0;
            mem_rdata  <= 32'h0;
        end else begin
            gnt_q      <= mem_req;
            mem_rvalid <= mem_req && mem_gnt;
            mem_rdata  <= (mem_req && mem_gnt) ? (mem_addr ^ 32'hDEAD_0000) : 32'h0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_gnt) acc_q.push_back(mem_addr);
    end

    // Waits from the current cycle for imem_resp; lat = -1 on timeout.
    task automatic wait_resp(output int lat, output logic [31:0] data);
        lat  = -1;
        data = 32'h0;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            @(negedge clk);
            if (imem_resp === 1'b1) begin
                lat  = i;
                data = imem_rdata;
            end else begin
                @(posedge clk);
            end
        end
    endtask

    // One-cycle request; latency counted from the LOOKUP cycle.
    task automatic fetch(input logic [31:0] addr, output int lat, output logic [31:0] data);
        @(posedge clk); #1;
        imem_valid = 1'b1;
        imem_addr  = addr;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        wait_resp(lat, data);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        imem_valid = 1'b0;
        imem_addr  = 32'h0;
        flush      = 1'b0;
        stall      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (imem_resp !== 1'b0 || imem_rdata !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_core: resp=%b rdata=%h, expected 0/00000000", imem_resp, imem_rdata);
        end
        n_checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_mem: req=%b addr=%h, expected 0/00000000", mem_req, mem_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_resp !== 1'b0 || imem_rdata !== 32'h0 || mem_req !== 1'b0) begin
            n_fails++;
            $display("FAIL post_reset_idle: resp=%b rdata=%h req=%b, expected 0", imem_resp,
                     imem_rdata, mem_req);
        end
    endtask

    task automatic test_cold_miss();
        int          lat;
        logic [31:0] data;
        logic [31:0] exp;
        acc_q.delete();
        fetch(32'h8000_0000, lat, data);
        n_checks++;
        if (lat != 7 || data !== 32'h5EAD_0000) begin
            n_fails++;
            $display("FAIL cold_miss: lat=%0d data=%h, expected lat=7 data=5ead0000", lat, data);
        end
        n_checks++;
        if (acc_q.size() != 4) begin
            n_fails++;
            $display("FAIL cold_miss_nreq: got %0d requests, expected 4", acc_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            exp = 32'h8000_0000 + 32'(4 * i);
            n_checks++;
            if (acc_q.size() <= i || acc_q[i] !== exp) begin
                n_fails++;
                $display("FAIL cold_miss_addr%0d: got %h, expected %h", i,
                         (acc_q.size() > i) ? acc_q[i] : 32'hx, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        exp[0] = 32'h5EAD_0004;
        exp[1] = 32'h5EAD_0008;
        exp[2] = 32'h5EAD_000C;
        acc_q.delete();
        @(posedge clk); #1;
        imem_valid = 1'b1;
        imem_addr  = 32'h8000_0004;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i < 2) imem_addr = 32'h8000_0008 + 32'(4 * i);
            else imem_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (imem_resp !== 1'b1 || imem_rdata !== exp[i] || mem_req !== 1'b0) begin
                n_fails++;
                $display("FAIL b2b_hit%0d: resp=%b rdata=%h req=%b, expected 1/%h/0", i, imem_resp,
                         imem_rdata, mem_req, exp[i]);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (imem_resp !== 1'b0 || imem_rdata !== 32'h0 || acc_q.size() != 0) begin
            n_fails++;
            $display("FAIL b2b_idle: resp=%b rdata=%h nreq=%0d, expected 0/0/0", imem_resp,
                     imem_rdata, acc_q.size());
        end
    endtask

    task automatic test_conflict();
        int          lat;
        logic [31:0] data;
        acc_q.delete();
        fetch(32'h8000_0100, lat, data);
        n_checks++;
        if (lat != 7 || data !== 32'h5EAD_0100) begin
            n_fails++;
            $display("FAIL evict_fill: lat=%0d data=%h, expected lat=7 data=5ead0100", lat, data);
        end
        n_checks++;
        if (acc_q.size() != 4 || acc_q[0] !== 32'h8000_0100 || acc_q[3] !== 32'h8000_010C) begin
            n_fails++;
            $display("FAIL evict_addrs: nreq=%0d first=%h, expected 4 from 80000100",
                     acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 32'hx);
        end
        fetch(32'h8000_0000, lat, data);
        n_checks++;
        if (lat != 7 || data !== 32'h5EAD_0000) begin
            n_fails++;
            $display("FAIL evict_remiss: lat=%0d data=%h, expected lat=7 data=5ead0000", lat, data);
        end
    endtask

    task automatic test_flush_idle();
        int          lat;
        logic [31:0] data;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        fetch(32'h8000_0000, lat, data);
        n_checks++;
        if (lat != 7 || data !== 32'h5EAD_0000) begin
            n_fails++;
            $display("FAIL flush_idle: lat=%0d data=%h, expected lat=7 data=5ead0000", lat, data);
        end
        // Hit in the same cycle as a flush still responds, then the line is gone
        @(posedge clk); #1;
        imem_valid = 1'b1;
        imem_addr  = 32'h8000_0008;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        flush      = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_resp !== 1'b1 || imem_rdata !== 32'h5EAD_0008) begin
            n_fails++;
            $display("FAIL flush_hit: resp=%b rdata=%h, expected 1/5ead0008", imem_resp, imem_rdata);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        fetch(32'h8000_0008, lat, data);
        n_checks++;
        if (lat != 7 || data !== 32'h5EAD_0008) begin
            n_fails++;
            $display("FAIL flush_hit_after: lat=%0d data=%h, expected lat=7 data=5ead0008", lat,
                     data);
        end
    endtask

    task automatic test_flush_refill();
        int          lat;
        logic [31:0] data;
        @(posedge clk); #1;
        imem_valid = 1'b1;
        imem_addr  = 32'h8000_0040;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        n_checks++;
        @(negedge clk);
        if (imem_resp !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_refill_miss: resp=%b, expected 0", imem_resp);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_resp(lat, data);
        n_checks++;
        if (lat != 4 || data !== 32'h5EAD_0040) begin
            n_fails++;
            $display("FAIL flush_refill_word: lat=%0d data=%h, expected lat=4 data=5ead0040", lat,
                     data);
        end
        fetch(32'h8000_0044, lat, data);
        n_checks++;
        if (lat != 7 || data !== 32'h5EAD_0044) begin
            n_fails++;
            $display("FAIL flush_refill_same: lat=%0d data=%h, expected lat=7 data=5ead0044", lat,
                     data);
        end
        fetch(32'h8000_0000, lat, data);
        n_checks++;
        if (lat != 7 || data !== 32'h5EAD_0000) begin
            n_fails++;
            $display("FAIL flush_refill_other: lat=%0d data=%h, expected lat=7 data=5ead0000", lat,
                     data);
        end
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [31:0] data;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        stall = 1'b1;
        acc_q.delete();
        imem_valid = 1'b1;
        imem_addr  = 32'h8000_0000;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0000) begin
                n_fails++;
                $display("FAIL stall_hold%0d: req=%b addr=%h, expected 1/80000000", i, mem_req,
                         mem_addr);
            end
        end
        @(posedge clk); #1;
        stall = 1'b0;
        wait_resp(lat, data);
        n_checks++;
        if (lat != 5 || data !== 32'h5EAD_0000) begin
            n_fails++;
            $display("FAIL stall_done: lat=%0d data=%h, expected lat=5 data=5ead0000", lat, data);
        end
        n_checks++;
        if (acc_q.size() != 4 || acc_q[0] !== 32'h8000_0000 || acc_q[3] !== 32'h8000_000C) begin
            n_fails++;
            $display("FAIL stall_addrs: nreq=%0d, expected 4 from 80000000", acc_q.size());
        end
    endtask

    task automatic test_reset_refill();
        int          lat;
        logic [31:0] data;
        @(posedge clk); #1;
        imem_valid = 1'b1;
        imem_addr  = 32'h8000_0080;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_resp !== 1'b0 || imem_rdata !== 32'h0 || mem_req !== 1'b0 ||
            mem_addr !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_refill_out: resp=%b rdata=%h req=%b addr=%h, expected all 0",
                     imem_resp, imem_rdata, mem_req, mem_addr);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        acc_q.delete();
        fetch(32'h8000_0080, lat, data);
        n_checks++;
        if (lat != 7 || data !== 32'h5EAD_0080 || acc_q.size() != 4) begin
            n_fails++;
            $display("FAIL reset_refill_again: lat=%0d data=%h nreq=%0d, expected 7/5ead0080/4",
                     lat, data, acc_q.size());
        end
        fetch(32'h8000_0000, lat, data);
        n_checks++;
        if (lat != 7 || data !== 32'h5EAD_0000) begin
            n_fails++;
            $display("FAIL reset_cleared: lat=%0d data=%h, expected lat=7 data=5ead0000", lat, data);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_flush_idle();
        test_flush_refill();
        test_backpressure();
        test_reset_refill();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the fetch stage.
- Serves the fetch-side I$ request port (address, valid, read data, response).
- Refills whole lines from a word-wide, in-order, pipelined memory port.
- Hits return one cycle after the request is sampled. A flush input invalidates all lines for fence.i support.

Parameters:
- ADDRW, 32, address width (matches orion_types ADDRW).
- DATAW, 32, instruction/word width (matches orion_types DATAW).
- NUM_LINES, 16, number of lines; power of two, at least 2.
- LINE_WORDS, 4, words per line; power of two, at least 2.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- imem_addr_i  in  ADDRW  fetch address; bits [1:0] ignored.
- imem_valid_i  in  1  fetch request valid.
- imem_rdata_o  out  DATAW  instruction word; 0 when imem_resp_o is low.
- imem_resp_o  out  1  response valid for the most recently accepted request.
- flush_i  in  1  invalidate all lines (single-cycle pulse).
- mem_req_o  out  1  memory word read request.
- mem_addr_o  out  ADDRW  word-aligned memory address.
- mem_gnt_i  in  1  request accepted when mem_req_o and mem_gnt_i are both high.
- mem_rvalid_i  in  1  read data valid; data returns in request order.
- mem_rdata_i  in  DATAW  read data.

Behaviour:
- Address split:
  - offset [1:0]
  - word select [2+WB-1:2], where WB = log2(LINE_WORDS)
  - index: next log2(NUM_LINES) bits
  - tag: remaining upper bits
- Storage:
  - valid bit per line (reset); tag array and data array (not reset).
  - Request address register req_addr_q.
- Reset (rst_ni low, async):
  - state IDLE; all valid bits 0; counters 0.
  - imem_resp_o 0, imem_rdata_o 0, mem_req_o 0, mem_addr_o 0.
- Accept rule: in IDLE, LOOKUP and RESPOND, imem_valid_i high latches imem_addr_i into req_addr_q and the next state is LOOKUP. Otherwise the next state is IDLE, unless a miss occurs.
- State IDLE: no outputs asserted.
- State LOOKUP: compare tag at index(req_addr_q).
  - Hit (valid and tag equal): imem_resp_o=1 and imem_rdata_o=data[index][word] in this cycle; apply the accept rule. Back-to-back hits sustain 1 response per cycle.
  - Miss: imem_resp_o=0; imem_valid_i and imem_addr_i are ignored; go to REFILL.
- State REFILL:
  - Issue LINE_WORDS requests, mem_addr_o = {tag,index,req_cnt,2'b00}, req_cnt from 0 upward.
  - req_cnt advances on each grant; mem_req_o drops once all LINE_WORDS are granted.
  - Each mem_rvalid_i writes mem_rdata_i into data[index][rsp_cnt]; rsp_cnt increments.
  - Requests and responses may overlap; at most LINE_WORDS outstanding.
  - On the last response: write the tag, set valid (unless flush is pending), go to RESPOND.
  - Core-side inputs are ignored throughout; the core holds its request.
- State RESPOND: forced hit; imem_resp_o=1 with data[index(req_addr_q)][word(req_addr_q)]; apply the accept rule.
- Miss latency: with grant and rvalid each one cycle after the request, the response comes LINE_WORDS+3 cycles after the miss LOOKUP cycle.
- Flush:
  - flush_i in IDLE/LOOKUP/RESPOND clears all valid bits at the next edge.
  - A hit presented in the same cycle as a flush still responds.
  - flush_i during REFILL sets flush_pend. On refill completion all valid bits are cleared, the refilled line is not marked valid, and RESPOND still returns the fetched word. flush_pend then clears.
- Counters wrap naturally at LINE_WORDS; rsp_cnt == LINE_WORDS-1 with rvalid marks completion.
- mem_rvalid_i outside REFILL is ignored. The memory side must be reset with this block, so a reset mid-refill abandons the fill and leaves the line invalid.
- No X on outputs after reset; imem_rdata_o is gated to 0 whenever imem_resp_o is low.

Test Plan:
- Cold miss: reset, request 0x8000_0000 -> mem requests to 0x8000_0000/04/08/0C in order; imem_resp_o high with mem word 0 exactly 7 cycles after the LOOKUP cycle (1-cycle grant/rvalid).
- Sequential hits: after the fill, requests 0x8000_0004, 08, 0C on consecutive cycles -> imem_resp_o high 3 consecutive cycles with the matching words; no mem_req_o.
- Conflict eviction: fill 0x8000_0000, then request 0x8000_0100 (same index 0, different tag) -> miss and refill from 0x8000_0100; a subsequent 0x8000_0000 misses again.
- Backpressure: hold mem_gnt_i low 5 cycles during refill -> mem_addr_o stable at 0x8000_0000 with mem_req_o held; completes correctly once granted.
- Flush: pulse flush_i in IDLE -> the next request to a previously filled 0x8000_0000 misses. Pulse flush_i mid-refill -> the word is still returned, and the following same-line request misses.
- Reset mid-refill: drop rst_ni after 2 responses -> outputs 0 immediately; after release, 0x8000_0000 misses and refills fully.
